// File: rtl/aes_stream_pipeline_top.sv
// -----------------------------------------------------------------------------
// aes_stream_pipeline_top
//
// Streaming wrapper around a pipelined AES-128 encryption core.
// The wrapper adds three things:
//   - a runtime key load, which is only allowed while no blocks are in flight
//   - a valid/ready plaintext input that carries a user tag with each block
//   - a first-word-fall-through output FIFO with backpressure
// Admission is credit based: a block is accepted only if it is certain to find
// a free FIFO slot when it leaves the core.
//
// Ports (clk rising edge; rs synchronous, active-high):
//   key_valid/key_data/key_ready  key load handshake (128-bit key)
//   in_valid/in_data/in_tag       plaintext block stream; accepted on in_valid && in_ready
//   in_ready
//   out_valid/out_data/out_tag    ciphertext stream; popped on out_valid && out_ready
//   out_ready
//   busy                          blocks in flight or FIFO not empty
// Optional (macro AES_STREAM_STATS_EN):
//   blk_in_cnt, blk_out_cnt       accepted / popped block counters (wrap at 2^32)
//   key_stall                     sticky: a key request was held off in DRAIN
//
// The included AES_pipeline_Encryption core has a fixed latency of 10 edges,
// so PIPE_LATENCY has to stay at 10 while that core is in use.
// -----------------------------------------------------------------------------

// AES-128 encryption, one round per pipeline stage. The round keys are derived
// combinationally from 'key'; this holds because the wrapper never changes the
// key while a real block is inside the pipeline.
module AES_pipeline_Encryption (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] cypher
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed arithmetically: x^254 is the GF(2^8) inverse (0 maps to 0),
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
  // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  function automatic logic [10:0][127:0] expand_key(input logic [127:0] k);
    logic [10:0][127:0] o;
    logic [31:0]        w0, w1, w2, w3, t;
    logic [7:0]         rcon;
    {w0, w1, w2, w3} = k;
    rcon = 8'h01;
    o[0] = k;
    for (int r = 1; r <= 10; r++) begin
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      o[r] = {w0, w1, w2, w3};
      rcon = xtime(rcon);
    end
    return o;
  endfunction

  logic [10:0][127:0] rk;
  logic [9:0][127:0]  st;   // st[i] holds the output of round i+1

  assign rk = expand_key(key);

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its neighbour's pre-edge value, giving a true shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= '0;
    end else begin
      st[0] <= aes_round(plaintext ^ rk[0], rk[1], 1'b0);
      for (int i = 1; i < 10; i++) st[i] <= aes_round(st[i-1], rk[i+1], i == 9);
    end
  end

  assign cypher = st[9];

endmodule

module aes_stream_pipeline_top #(
  parameter int PIPE_LATENCY = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             key_valid,
  input  logic [127:0]     key_data,
  output logic             key_ready,
  input  logic             in_valid,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             out_valid,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic             busy
`ifdef AES_STREAM_STATS_EN
  ,
  output logic [31:0]      blk_in_cnt,
  output logic [31:0]      blk_out_cnt,
  output logic             key_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + PIPE_LATENCY + 1);

  typedef enum logic [1:0] {NO_KEY, RUN, DRAIN} state_t;

  state_t                             state, state_nxt;
  logic [127:0]                       key_q;
  logic [127:0]                       cypher;
  logic [PIPE_LATENCY-1:0]            vsr;
  logic [PIPE_LATENCY-1:0][TAG_W-1:0] tsr;
  logic [CW-1:0]                      inflight, fifo_count;
  logic [AW-1:0]                      wr_ptr, rd_ptr;
  logic [TAG_W+127:0]                 mem [FIFO_DEPTH];
  logic [TAG_W+127:0]                 head;
  logic                               accept, key_accept, pipe_out, pop, credit_ok;

  AES_pipeline_Encryption u_core (
    .clk       (clk),
    .reset     (rs),
    .plaintext (in_data),
    .key       (key_q),
    .cypher    (cypher)
  );

  // Every accepted block holds a credit until it is popped, so the FIFO can
  // never be full when a block leaves the core.
  assign credit_ok  = (inflight + fifo_count) < CW'(FIFO_DEPTH);
  assign accept     = in_valid && in_ready;
  assign key_accept = key_valid && key_ready;
  assign pipe_out   = vsr[PIPE_LATENCY-1];
  assign pop        = out_valid && out_ready;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      NO_KEY: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = RUN;
      end
      RUN: begin
        key_ready = (inflight == '0);
        // A key load wins over a block offered in the same cycle.
        in_ready  = credit_ok && !(key_valid && inflight == '0);
        if (key_valid && inflight != '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) state_nxt = RUN;
      end
      default: state_nxt = NO_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state      <= NO_KEY;
      key_q      <= '0;
      vsr        <= '0;
      tsr        <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (key_accept) key_q <= key_data;
      vsr[0] <= accept;
      tsr[0] <= in_tag;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vsr[i] <= vsr[i-1];
        tsr[i] <= tsr[i-1];
      end
      case ({accept, pipe_out})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if (pipe_out) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({pipe_out, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; only the pointers and
  // count are, and out_data/out_tag are forced to zero while the FIFO is empty,
  // so stale entries can never be observed.
  always_ff @(posedge clk) begin
    if (pipe_out) mem[wr_ptr] <= {tsr[PIPE_LATENCY-1], cypher};
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head[127:0] : '0;
  assign out_tag   = out_valid ? head[TAG_W+127:128] : '0;
  assign busy      = (inflight != '0) || (fifo_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rs)
    !(pipe_out && fifo_count == CW'(FIFO_DEPTH)));

`ifdef AES_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rs) begin
      blk_in_cnt  <= '0;
      blk_out_cnt <= '0;
      key_stall   <= 1'b0;
    end else begin
      if (accept) blk_in_cnt  <= blk_in_cnt + 32'd1;
      if (pop)    blk_out_cnt <= blk_out_cnt + 32'd1;
      if (state == DRAIN && key_valid) key_stall <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_stream_pipeline_top.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_pipeline_top
//
// Directed bench for aes_stream_pipeline_top. Expected ciphertexts are the
// published AES-128 example vectors; a queue of {ciphertext, tag} pushed at
// every accept gives the required output order.
// -----------------------------------------------------------------------------
module tb_aes_stream_pipeline_top;

  localparam int PIPE_LATENCY = 10;
  localparam int FIFO_DEPTH   = 16;
  localparam int TAG_W        = 4;

  localparam logic [127:0] K1 = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] P1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C1 = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rs;
  logic             key_valid;
  logic [127:0]     key_data;
  logic             key_ready;
  logic             in_valid;
  logic [127:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic             out_valid;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_ready;
  logic             busy;

  int                 total = 0;
  int                 bad   = 0;
  int                 n_acc = 0;
  int                 n;
  int                 seen;
  logic [127:0]       cur_exp;
  logic [TAG_W+127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_stream_pipeline_top #(
    .PIPE_LATENCY (PIPE_LATENCY),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .TAG_W        (TAG_W)
  ) dut (
    .clk       (clk),
    .rs        (rs),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: record accepts, check pops against the queue, advance past the edge.
  task automatic step();
    logic [TAG_W+127:0] e;
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back({cur_exp, in_tag});
      n_acc++;
    end
    if (out_valid && out_ready) begin
      check("out_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[TAG_W+127:TAG_W]);
        check("out_tag", 128'(out_tag), 128'(e[TAG_W-1:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      step();
      k++;
    end
    check(tag, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    rs = 1'b1; key_valid = 1'b0; key_data = '0; in_valid = 1'b0;
    in_data = '0; in_tag = '0; out_ready = 1'b0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    rs = 1'b0;
    settle();
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data",  out_data,        128'd0);
    check("rst_out_tag",   128'(out_tag),   128'd0);
    check("rst_busy",      128'(busy),      128'd0);

    // No key loaded: offered blocks are refused and nothing comes out.
    out_ready = 1'b1; in_valid = 1'b1; in_data = P1; in_tag = 4'h5;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      check("nokey_in_ready", 128'(in_ready), 128'd0);
      if (out_valid) seen++;
    end
    check("nokey_no_output", 128'(seen), 128'd0);
    in_valid = 1'b0;

    // Single block, key K1: value, tag and latency.
    out_ready = 1'b0; key_valid = 1'b1; key_data = K1;
    settle();
    check("t1_key_ready", 128'(key_ready), 128'd1);
    step();
    key_valid = 1'b0;
    settle();
    check("t1_in_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1; in_data = P1; in_tag = 4'd3; cur_exp = C1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("t1_latency",  128'(n + 1), 128'(PIPE_LATENCY + 1));
    check("t1_out_data", out_data, C1);
    check("t1_out_tag",  128'(out_tag), 128'd3);
    check("t1_busy",     128'(busy), 128'd1);
    out_ready = 1'b1;
    step();
    check("t1_empty_valid", 128'(out_valid), 128'd0);
    check("t1_empty_busy",  128'(busy), 128'd0);

    // Key K2, 20 back-to-back blocks with out_ready held high.
    key_valid = 1'b1; key_data = K2;
    settle();
    check("t2_key_ready", 128'(key_ready), 128'd1);
    step();
    key_valid = 1'b0; in_data = P2; cur_exp = C2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_tag = TAG_W'(i % 16);
      settle();
      check("t2_in_ready", 128'(in_ready), 128'd1);
      step();
    end
    in_valid = 1'b0;
    drain("t2_drained");
    check("t2_busy", 128'(busy), 128'd0);

    // Backpressure: exactly FIFO_DEPTH blocks admitted, then drained in order.
    out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      in_tag = TAG_W'(i);
      step();
    end
    check("t3_accepted",     128'(n_acc), 128'(FIFO_DEPTH));
    check("t3_in_ready_low", 128'(in_ready), 128'd0);
    check("t3_out_valid",    128'(out_valid), 128'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    drain("t3_drained");
    repeat (3) step();
    check("t3_no_dup", 128'(out_valid), 128'd0);

    // Key change with blocks in flight: DRAIN, then the new key.
    in_data = P2; cur_exp = C2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tag = TAG_W'(8 + i);
      step();
    end
    in_valid = 1'b0; key_valid = 1'b1; key_data = K1;
    settle();
    check("t4_key_ready_inflight", 128'(key_ready), 128'd0);
    step();
    check("t4_drain_in_ready",  128'(in_ready),  128'd0);
    check("t4_drain_key_ready", 128'(key_ready), 128'd0);
    n = 0;
    while (!key_ready && n < 40) begin
      step();
      n++;
      check("t4_wait_in_ready", 128'(in_ready), 128'd0);
    end
    check("t4_drain_cycles", 128'(n), 128'd10);
    step();
    key_valid = 1'b0;
    settle();
    check("t4_run_in_ready", 128'(in_ready), 128'd1);
    in_data = P1; cur_exp = C1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tag = TAG_W'(12 + i);
      step();
    end
    in_valid = 1'b0;
    drain("t4_drained");

    // Reset with 3 blocks buffered and 5 in flight.
    out_ready = 1'b0; in_data = P1; cur_exp = C1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tag = TAG_W'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    check("t5_fifo_holds", 128'(out_valid), 128'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_tag = TAG_W'(4 + i);
      step();
    end
    in_valid = 1'b0;
    rs = 1'b1;
    step();
    rs = 1'b0;
    exp_q.delete();
    settle();
    check("t5_out_valid", 128'(out_valid), 128'd0);
    check("t5_busy",      128'(busy),      128'd0);
    check("t5_in_ready",  128'(in_ready),  128'd0);
    check("t5_key_ready", 128'(key_ready), 128'd1);
    check("t5_out_data",  out_data,        128'd0);
    out_ready = 1'b1; in_valid = 1'b1; seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) seen++;
      check("t5_nokey_in_ready", 128'(in_ready), 128'd0);
    end
    check("t5_no_stale", 128'(seen), 128'd0);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
